sdram_arbit_ctrl: RTL and testbench

//  Sole owner of the SDRAM command/address/DQ pins. Sequences init, then grants the bus
//  to one of auto-refresh, write-burst and read-burst engines. Muxes the granted

---
 rtl/sdram_arbit_ctrl_pkg.sv | 34 +++
 rtl/sdram_arb_pick.sv | 38 +++
 rtl/sdram_arbit_ctrl.sv | 138 +++++++++++++
 tb/tb_sdram_arbit_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbit_ctrl_pkg.sv
// Shared SDRAM constants: command codes, idle bank/address, arbiter state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sdram_arbit_ctrl_pkg;

    // Commands are {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0]  CMD_NOP       = 4'b0111;
    localparam logic [3:0]  CMD_PRE_CHA   = 4'b0010;
    localparam logic [3:0]  CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0]  CMD_WRITE     = 4'b0100;
    localparam logic [3:0]  CMD_READ      = 4'b0101;
    localparam logic [3:0]  CMD_AREF      = 4'b0001;
    localparam logic [3:0]  CMD_BURST_TER = 4'b0110;

    localparam logic [1:0]  IDLE_BA   = 2'b11;
    localparam logic [12:0] IDLE_ADDR = 13'h1fff;

    // One-hot arbiter states.
    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_t;

    // One-hot grant decision from the picker.
    typedef struct packed {
        logic aref;
        logic wr;
        logic rd;
    } grant_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational picker: refresh first, then write/read (fixed or round-robin).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; requests are levels and are simply re-evaluated every cycle.
// Ports: aref_req/wr_req/rd_req in, last_wr in (SDRAM_ARB_RR_EN only), pick one-hot out.
// Macro SDRAM_ARB_RR_EN: alternate write/read when both pend; otherwise write wins.
module sdram_arb_pick
    import sdram_arbit_ctrl_pkg::*;
(
    input  logic   aref_req,
    input  logic   wr_req,
    input  logic   rd_req,
`ifdef SDRAM_ARB_RR_EN
    input  logic   last_wr,
`endif
    output grant_t pick
);

    always_comb begin
        pick = '0;
        if (aref_req) begin
            pick.aref = 1'b1;
        end
`ifdef SDRAM_ARB_RR_EN
        else if (wr_req && rd_req) begin
            // Both pending: hand the bus to whichever did not have it last.
            if (last_wr) pick.rd = 1'b1;
            else         pick.wr = 1'b1;
        end
`endif
        else if (wr_req) begin
            pick.wr = 1'b1;
        end
        else if (rd_req) begin
            pick.rd = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbit_ctrl.sv
// SDRAM pin owner: runs init, then grants refresh/write/read engines and muxes their pins.
// Latency: grant 1 cycle after request seen in ARBIT; pins/grants combinational on state.
// Backpressure: requests are held levels; a grant lasts until the engine's *_end pulse.
// Ports: init_*, aref_*, wr_*, rd_* engine inputs; aref_en/wr_en/rd_en grants;
//        sdram_cke/cmd/ba/addr/dq_oe/dq_out pin outputs. Clock sys_clk, async reset sys_rst_n.
// Macro SDRAM_ARB_RR_EN: round-robin between write and read (refresh keeps top priority).
module sdram_arbit_ctrl
    import sdram_arbit_ctrl_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic [15:0] sdram_dq_out
);

    arb_state_t state;
    grant_t     pick;

`ifdef SDRAM_ARB_RR_EN
    logic last_wr;
`endif

    sdram_arb_pick u_pick (
        .aref_req (aref_req),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
`ifdef SDRAM_ARB_RR_EN
        .last_wr  (last_wr),
`endif
        .pick     (pick)
    );

    // Every grant returns to ARBIT, so there is always at least one NOP cycle
    // between consecutive grants.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_INIT;
`ifdef SDRAM_ARB_RR_EN
            last_wr <= 1'b0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_end) state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (pick.aref) begin
                        state <= ST_AREF;
                    end else if (pick.wr) begin
                        state <= ST_WRITE;
`ifdef SDRAM_ARB_RR_EN
                        last_wr <= 1'b1;
`endif
                    end else if (pick.rd) begin
                        state <= ST_READ;
`ifdef SDRAM_ARB_RR_EN
                        last_wr <= 1'b0;
`endif
                    end
                end
                ST_AREF: begin
                    if (aref_end) state <= ST_ARBIT;
                end
                ST_WRITE: begin
                    if (wr_end) state <= ST_ARBIT;
                end
                ST_READ: begin
                    if (rd_end) state <= ST_ARBIT;
                end
                default: state <= ST_ARBIT;
            endcase
        end
    end

    assign aref_en   = (state == ST_AREF);
    assign wr_en     = (state == ST_WRITE);
    assign rd_en     = (state == ST_READ);
    assign sdram_cke = 1'b1;

    // Pin mux; ARBIT and any illegal encoding drive the idle NOP pattern.
    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_ba     = IDLE_BA;
        sdram_addr   = IDLE_ADDR;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = 16'h0;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
            end
            ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_ba     = wr_ba;
                sdram_addr   = wr_addr;
                sdram_dq_oe  = wr_sdram_en;
                sdram_dq_out = wr_sdram_data;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit_ctrl.sv
// Scoreboard bench for sdram_arbit_ctrl: stimulus queues expected grants, monitor checks them.
// Latency: n/a. Backpressure: engine models hold requests until granted (or forever when held).
module tb_sdram_arbit_ctrl;

    localparam logic [2:0] G_AREF = 3'b100;
    localparam logic [2:0] G_WR   = 3'b010;
    localparam logic [2:0] G_RD   = 3'b001;
    localparam logic [3:0] NOP    = 4'b0111;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_out;

    sdram_arbit_ctrl dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .init_end      (init_end),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cmd     (sdram_cmd),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq_oe   (sdram_dq_oe),
        .sdram_dq_out  (sdram_dq_out)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [2:0] exp_q[$];

    // Engine model state (driven only by the stimulus process).
    int   aref_cnt, wr_cnt, rd_cnt;
    logic hold_wr, hold_rd;
    logic [2:0] tick_prev;
    int   starts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of engine behaviour: 3-cycle bursts, *_end on the 3rd granted cycle.
    task automatic tick();
        logic [2:0] cur;
        @(negedge sys_clk);
        cur = {aref_en, wr_en, rd_en};
        if (cur != 3'b000 && cur != tick_prev) starts++;
        tick_prev = cur;
        if (aref_en) begin
            aref_req = 1'b0;
            aref_cnt++;
            aref_end = (aref_cnt == 3);
            if (aref_end) aref_cnt = 0;
        end else begin
            aref_end = 1'b0;
            aref_cnt = 0;
        end
        if (wr_en) begin
            if (!hold_wr) wr_req = 1'b0;
            wr_cnt++;
            wr_end        = (wr_cnt == 3);
            wr_sdram_en   = (wr_cnt >= 2);
            wr_sdram_data = 16'hBE00 | 16'(wr_cnt);
            if (wr_end) wr_cnt = 0;
        end else begin
            wr_end        = 1'b0;
            wr_cnt        = 0;
            wr_sdram_en   = 1'b0;
            wr_sdram_data = 16'h0;
        end
        if (rd_en) begin
            if (!hold_rd) rd_req = 1'b0;
            rd_cnt++;
            rd_end = (rd_cnt == 3);
            if (rd_end) rd_cnt = 0;
        end else begin
            rd_end = 1'b0;
            rd_cnt = 0;
        end
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !aref_en && !wr_en && !rd_en
                   && !aref_req && !wr_req && !rd_req;
        end
        check(name, done, 1);
    endtask

    // Monitor: on each new grant, pop the expected engine and check pins and the NOP gap.
    initial begin
        logic [2:0] prev_g, cur;
        logic [3:0] prev_cmd;
        prev_g   = 3'b000;
        prev_cmd = NOP;
        forever begin
            @(negedge sys_clk);
            #1;
            cur = {aref_en, wr_en, rd_en};
            if (!sys_rst_n) begin
                prev_g   = 3'b000;
                prev_cmd = 4'h0;
            end else begin
                if (cur != 3'b000 && cur != prev_g) begin
                    if (exp_q.size() == 0) check("unexpected_grant", 32'(cur), 0);
                    else                   check("grant_order", 32'(cur), 32'(exp_q.pop_front()));
                    check("nop_before_grant", {prev_g, prev_cmd}, {3'b000, NOP});
                    if (cur == G_WR) begin
                        check("wr_pins", {sdram_cmd, sdram_ba, sdram_addr}, {wr_cmd, wr_ba, wr_addr});
                        check("wr_dq", {sdram_dq_oe, sdram_dq_out}, {wr_sdram_en, wr_sdram_data});
                    end else if (cur == G_RD) begin
                        check("rd_pins", {sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe},
                              {rd_cmd, rd_ba, rd_addr, 1'b0});
                    end else begin
                        check("aref_pins", {sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe},
                              {aref_cmd, 2'b11, 13'h1fff, 1'b0});
                    end
                end
                prev_g   = cur;
                prev_cmd = sdram_cmd;
            end
        end
    end

    initial begin
        logic seen;
        int   base;
        sys_rst_n = 1'b0;
        init_end  = 1'b0;
        init_cmd  = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
        aref_req  = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001;
        wr_req    = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123;
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h0;
        rd_req    = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0456;
        aref_cnt = 0; wr_cnt = 0; rd_cnt = 0; hold_wr = 1'b0; hold_rd = 1'b0;
        tick_prev = 3'b000; starts = 0;

        // 1. Reset and init sequencing.
        #12;
        check("rst_grants", {aref_en, wr_en, rd_en}, 0);
        check("rst_cke", sdram_cke, 1);
        check("rst_pins", {sdram_cmd, sdram_ba, sdram_addr}, {4'b0010, 2'b01, 13'h0400});
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("init_hold_cmd", sdram_cmd, 4'b0010);
        check("init_hold_grants", {aref_en, wr_en, rd_en, sdram_dq_oe}, 0);
        init_end = 1'b1;
        tick();
        check("arbit_idle_pins", {sdram_cmd, sdram_ba, sdram_addr}, {NOP, 2'b11, 13'h1fff});
        check("arbit_cke", sdram_cke, 1);

        // 2. Single write burst.
        wr_req = 1'b1;
        exp_q.push_back(G_WR);
        tick();
        check("t2_wr_en_next", wr_en, 1);
        check("t2_wr_addr", {sdram_ba, sdram_addr}, {2'b10, 13'h0123});
        tick();
        check("t2_dq_oe_on", {sdram_dq_oe, sdram_dq_out}, {1'b1, 16'hBE02});
        tick();
        check("t2_wr_end_en", {wr_end, wr_en}, 2'b11);
        tick();
        check("t2_after_end", {wr_en, sdram_cmd, sdram_dq_oe}, {1'b0, NOP, 1'b0});
        wait_idle("t2_idle");

        // 3. All three requests in the same cycle.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        exp_q.push_back(G_AREF);
`ifdef SDRAM_ARB_RR_EN
        exp_q.push_back(G_RD);
        exp_q.push_back(G_WR);
`else
        exp_q.push_back(G_WR);
        exp_q.push_back(G_RD);
`endif
        wait_idle("t3_idle");

        // 4. Refresh raised mid-write waits for wr_end.
        wr_req = 1'b1;
        exp_q.push_back(G_WR);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = wr_en; end
        check("t4_wr_grant", seen, 1);
        tick();
        aref_req = 1'b1;
        exp_q.push_back(G_AREF);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = wr_end; end
        check("t4_wr_end_seen", {seen, wr_en, aref_en}, 3'b110);
        tick();
        check("t4_gap", {aref_en, sdram_cmd}, {1'b0, NOP});
        tick();
        check("t4_aref_2cyc", aref_en, 1);
        wait_idle("t4_idle");

        // 5. Write and read held for four bursts.
        hold_wr = 1'b1; hold_rd = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
`ifdef SDRAM_ARB_RR_EN
        exp_q.push_back(G_RD); exp_q.push_back(G_WR);
        exp_q.push_back(G_RD); exp_q.push_back(G_WR);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(G_WR);
`endif
        base = starts;
        for (int i = 0; i < 200 && starts < base + 4; i++) tick();
        check("t5_four_bursts", starts - base, 4);
        hold_wr = 1'b0; hold_rd = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wait_idle("t5_idle");

        // 6. Reset mid-read aborts to INIT immediately.
        rd_req = 1'b1;
        exp_q.push_back(G_RD);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = rd_en; end
        check("t6_rd_grant", seen, 1);
        tick();
        check("t6_mid_read", {rd_en, sdram_cmd}, {1'b1, 4'b0101});
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_rst_pins", {sdram_cmd, sdram_dq_oe}, {4'b0010, 1'b0});
        tick();
        sys_rst_n = 1'b1;
        tick();
        check("t6_back_to_arbit", {sdram_cmd, rd_en}, {NOP, 1'b0});
        check("exp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
